axicb_slv_cpl_mux: RTL
======================

// Module: axicb_slv_cpl_mux
// PURPOSE
// - Completion-side stage directly after axicb_slv_ooo, one instance per master port.
// - Takes the ooo grant attributes (c_grant/c_mr/c_len/c_id) and forwards the granted slave's R or B channel.
// - For misrouted requests it generates the completion itself: DECERR, zero data, c_len+1 beats on read.
// - Returns c_ready, c_en and mr_last to axicb_slv_ooo; registers the master-side completion channel.
// PARAMETERS
// - RD_PATH     0  1: read (R channel, bursts); 0: write (B channel, single beat)
// - AXI_ID_W    8  ID width
// - AXI_DATA_W  32 read data width; unused when RD_PATH=0
// - SLV_NB      4  number of slaves
// - CCH_W       derived: RD {data,resp,id} = AXI_DATA_W+2+AXI_ID_W; WR {resp,id} = 2+AXI_ID_W; ID at LSBs
// PORTS
// - aclk       in   1                clock
// - aresetn    in   1                synchronous active-low reset
// - c_grant    in   SLV_NB           one-hot granted slave from ooo; 0 = nothing granted
// - c_mr       in   1                granted transaction is misrouted
// - c_len      in   8                ALEN of granted transaction (RD only)
// - c_id       in   AXI_ID_W         ID of granted transaction
// - c_en       out  1                arbiter advance enable to ooo
// - c_ready    out  1                stage accepts a beat this cycle, to ooo
// - mr_last    out  1                current generated misrouted beat is last
// - s_valid    in   SLV_NB           per-slave completion valid
// - s_ready    out  SLV_NB           per-slave completion ready
// - s_last     in   SLV_NB           per-slave last (tie 1 on WR)
// - s_ch       in   CCH_W*SLV_NB     per-slave completion payload
// - m_valid    out  1                master completion valid
// - m_ready    in   1                master completion ready
// - m_last     out  1                master last (always 1 on WR)
// - m_id       out  AXI_ID_W         master completion ID
// - m_resp     out  2                master RRESP/BRESP
// - m_data     out  AXI_DATA_W       master read data; 0 on WR
// BEHAVIOUR
// - Reset: m_valid=0, m_last/m_id/m_resp/m_data=0, beat counter=0, state=IDLE, s_ready=0, c_en=0.
// - Output stage: one register slot, 1-cycle latency. acc = !m_valid | m_ready. Full throughput; payload held stable while m_valid & !m_ready.
// - c_ready = acc. Beat moves when src_valid & acc.
// - Normal path (c_grant!=0, c_mr=0): src = slave with c_grant[j]. s_ready[j] = c_grant[j] & acc; all other s_ready=0. Payload copied unchanged.
// - Misrouted path (c_grant!=0, c_mr=1): src_valid=1, s_ready=0. Beat: id=c_id, resp=2'b11 (DECERR), data=0.
// - FSM IDLE: first misrouted beat moves -> MR_BURST unless it is last. MR_BURST: last beat moves -> IDLE.
// - 8-bit beat counter cnt counts beats moved in the burst; zeroed when the last beat moves.
// - mr_last = c_mr & (RD_PATH ? cnt==c_len : 1). Depends only on registered cnt and ooo attributes; never on c_ready.
// - c_len=255 gives 256 beats; cnt reaches 255, then clears. No wrap beyond that.
// - c_en = 1 in the cycle the last beat of a completion (normal s_last or mr_last) moves, else 0. The grant is therefore held for the whole burst.
// - c_grant=0: src_valid=0, s_ready=0, c_en=0; the output slot drains normally.
// - m_ready=0 mid-burst: cnt frozen, s_ready=0, grant held.
// - A normal beat whose s_last=1 on WR is legal every cycle; back-to-back grants need no bubble.
// - Reset mid-burst: returns to the reset state next edge. Partial burst is dropped; ooo is reset by the same aresetn.
// - c_mr=1 has priority by construction: ooo never grants a slave and a misroute together.
// STRUCTURE
// - Shared package axicb_pkg holds:
//   - RESP_OKAY=2'b00 and RESP_DECERR=2'b11
//   - cpl_state_t enum {IDLE, MR_BURST}
//   - CCH field offset functions (id, resp, data) per RD_PATH
// - One sub-module: axicb_pipeline (DATA_BUS_W = 1+AXI_ID_W+2+AXI_DATA_W, NB_PIPELINE=1) as the output slot.
// - Mux, FSM and counter stay inline.
// TESTING
// - RD, slave 2 granted, 4 beats id=0x11, m_ready=1 -> 4 m beats, payload identical; m_last on beat 4; c_en=1 once, at beat 4.
// - RD misrouted, c_len=3, c_id=0x05 -> 4 beats: resp=2'b11, data=0, id=0x05. mr_last and m_last on beat 4. s_ready stays 0.
// - RD misrouted, c_len=255 -> exactly 256 beats. cnt=255 on last beat. c_en pulses once.
// - WR misrouted, c_id=0x2 -> single B beat with resp=2'b11, m_last=1; c_en and mr_last high the same cycle.
// - Normal RD with m_ready toggling 1010… -> no beat lost or duplicated; m_data stable while stalled; s_ready[j]=0 whenever m_valid & !m_ready.
// - Reset asserted on beat 2 of a misrouted 8-beat burst -> m_valid=0, cnt=0 next cycle; the next grant restarts at beat 0.

Source files
------------

// File: rtl/axicb_pkg.sv
// axicb shared definitions: response codes, completion FSM states
// and field offsets of the packed completion channel.
package axicb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE,
    MR_BURST
  } cpl_state_t;

  function automatic int cch_w(int rd, int id_w, int data_w);
    return (rd != 0) ? data_w + 2 + id_w : 2 + id_w;
  endfunction

  function automatic int cch_id_off();
    return 0;
  endfunction

  function automatic int cch_resp_off(int id_w);
    return id_w;
  endfunction

  function automatic int cch_data_off(int rd, int id_w);
    return (rd != 0) ? id_w + 2 : 0;
  endfunction

endpackage

// File: rtl/axicb_pipeline.sv
// axicb valid/ready register slot: full throughput, payload held
// stable while stalled. Depth 0 is a plain wire-through.
module axicb_pipeline #(
  parameter int DATA_BUS_W  = 8,
  parameter int NB_PIPELINE = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_BUS_W-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_BUS_W-1:0] dn_data
);

  generate
    if (NB_PIPELINE == 0) begin : g_bypass
      assign dn_valid = up_valid;
      assign up_ready = dn_ready;
      assign dn_data  = up_data;
    end else begin : g_slot
      logic                  vq;
      logic [DATA_BUS_W-1:0] dq;

      assign up_ready = !vq || dn_ready;
      assign dn_valid = vq;
      assign dn_data  = dq;

      // slot refills whenever it is empty or being drained
      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          vq <= 1'b0;
          dq <= '0;
        end else if (up_ready) begin
          vq <= up_valid;
          if (up_valid) dq <= up_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axicb_slv_cpl_mux.sv
// axicb completion mux: forwards the granted slave R/B channel or
// builds DECERR completions for misrouted requests.
module axicb_slv_cpl_mux
  import axicb_pkg::*;
#(
  parameter int RD_PATH    = 0,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 32,
  parameter int SLV_NB     = 4,
  parameter int CCH_W      = cch_w(RD_PATH, AXI_ID_W, AXI_DATA_W)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [SLV_NB-1:0]       c_grant,
  input  logic                    c_mr,
  input  logic [7:0]              c_len,
  input  logic [AXI_ID_W-1:0]     c_id,
  output logic                    c_en,
  output logic                    c_ready,
  output logic                    mr_last,
  input  logic [SLV_NB-1:0]       s_valid,
  output logic [SLV_NB-1:0]       s_ready,
  input  logic [SLV_NB-1:0]       s_last,
  input  logic [CCH_W*SLV_NB-1:0] s_ch,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [AXI_ID_W-1:0]     m_id,
  output logic [1:0]              m_resp,
  output logic [AXI_DATA_W-1:0]   m_data
);

  localparam int BUS_W    = 1 + AXI_ID_W + 2 + AXI_DATA_W;
  localparam int ID_OFF   = cch_id_off();
  localparam int RESP_OFF = cch_resp_off(AXI_ID_W);
  localparam int DATA_OFF = cch_data_off(RD_PATH, AXI_ID_W);

  logic                  slot_ready;
  logic                  acc;
  logic                  granted;
  logic                  nrm_valid;
  logic                  nrm_last;
  logic [CCH_W-1:0]      nrm_ch;
  logic [AXI_DATA_W-1:0] nrm_data;
  logic                  src_valid;
  logic                  src_last;
  logic [AXI_ID_W-1:0]   src_id;
  logic [1:0]            src_resp;
  logic [AXI_DATA_W-1:0] src_data;
  logic                  bus_last;
  logic                  move;
  logic [7:0]            cnt;
  logic [7:0]            cnt_nxt;
  cpl_state_t            state;
  cpl_state_t            state_nxt;

  assign acc     = slot_ready && aresetn;
  assign c_ready = acc;
  assign granted = |c_grant;

  // one-hot grant selects the slave channel by OR-reduction
  always_comb begin
    nrm_valid = 1'b0;
    nrm_last  = 1'b0;
    nrm_ch    = '0;
    for (int j = 0; j < SLV_NB; j++) begin
      if (c_grant[j]) begin
        nrm_valid = nrm_valid | s_valid[j];
        nrm_last  = nrm_last | s_last[j];
        nrm_ch    = nrm_ch | s_ch[j*CCH_W +: CCH_W];
      end
    end
  end

  generate
    if (RD_PATH != 0) begin : g_rd
      assign nrm_data = nrm_ch[DATA_OFF +: AXI_DATA_W];
    end else begin : g_wr
      assign nrm_data = '0;
    end
  endgenerate

  assign mr_last = c_mr && ((RD_PATH != 0) ? (cnt == c_len) : 1'b1);
  assign s_ready = (granted && !c_mr && acc) ? c_grant : '0;

  // source beat: generated DECERR on misroute, else slave payload
  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_id    = '0;
    src_resp  = RESP_OKAY;
    src_data  = '0;
    if (granted) begin
      if (c_mr) begin
        src_valid = 1'b1;
        src_last  = mr_last;
        src_id    = c_id;
        src_resp  = RESP_DECERR;
      end else begin
        src_valid = nrm_valid;
        src_last  = nrm_last;
        src_id    = nrm_ch[ID_OFF +: AXI_ID_W];
        src_resp  = nrm_ch[RESP_OFF +: 2];
        src_data  = nrm_data;
      end
    end
  end

  assign move     = src_valid && acc;
  assign c_en     = move && src_last;
  assign bus_last = (RD_PATH != 0) ? src_last : 1'b1;

  // next state and beat count of the current burst
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (move) cnt_nxt = src_last ? 8'd0 : cnt + 8'd1;
    unique case (state)
      IDLE:
        if (move && c_mr && !mr_last) state_nxt = MR_BURST;
      MR_BURST:
        if (move && src_last) state_nxt = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  axicb_pipeline #(
    .DATA_BUS_W  (BUS_W),
    .NB_PIPELINE (1)
  ) u_slot (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .up_valid (src_valid),
    .up_ready (slot_ready),
    .up_data  ({bus_last, src_id, src_resp, src_data}),
    .dn_valid (m_valid),
    .dn_ready (m_ready),
    .dn_data  ({m_last, m_id, m_resp, m_data})
  );

endmodule
